serial_cmp_ctrl: RTL and testbench
==================================

SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, unsigned operand width; it SHALL be even and >= 2.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start_valid  input  1  requester presents operands.
REQ-005 The block SHALL have port start_ready  output  1  block can accept operands.
REQ-006 The block SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-007 The block SHALL have port x  input  WIDTH  operand B, unsigned.
REQ-008 The block SHALL have port res_valid  output  1  result available.
REQ-009 The block SHALL have port res_ready  input  1  consumer takes result.
REQ-010 The block SHALL have ports gt, eq, ls  output  1 each  A>B, A=B, A<B.
REQ-011 The block SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE: start_ready=1.
- RUN and DONE: start_ready=0.
REQ-013 In IDLE, start_valid&&start_ready at an edge SHALL capture a and x into internal registers, clear the pair index to 0 and enter RUN.
REQ-014 In RUN, each cycle SHALL compare one 2-bit pair, MSB pair first.
- Pair j = bits [WIDTH-1-2j : WIDTH-2-2j] of the captured operands.
- Compared via the cmp2_slice instance.
REQ-015 If pair j is unequal, the next edge SHALL latch gt or ls from that pair and enter DONE (early exit).
REQ-016 If pair j is equal and j < WIDTH/2-1, the next edge SHALL increment j and remain in RUN.
REQ-017 If the last pair is equal, the next edge SHALL latch eq=1 and enter DONE.
REQ-018 Latency: with accept at edge 0 and first differing pair j, res_valid SHALL be high after edge j+1; with all pairs equal, after edge WIDTH/2.
REQ-019 In DONE, res_valid SHALL be 1 and exactly one of gt/eq/ls SHALL be 1; values SHALL hold stable while res_ready=0.
REQ-020 res_valid&&res_ready at an edge SHALL clear gt/eq/ls and res_valid and return to IDLE.
- No same-cycle re-accept; the next accept is possible one cycle later.
REQ-021 Outside DONE, gt, eq, ls and res_valid SHALL all be 0.
REQ-022 Changes on a or x after accept SHALL NOT affect the result.
REQ-023 start_valid outside IDLE SHALL be ignored; the requester holds it until start_ready.
REQ-024 The pair-index counter SHALL be $clog2(WIDTH/2) bits, minimum 1, and SHALL never exceed WIDTH/2-1.

Reset
REQ-025 rst=1 SHALL immediately, without a clock edge, force:
- state IDLE, start_ready=1, busy=0;
- res_valid=0, gt=0, eq=0, ls=0;
- pair index 0, operand registers 0.
REQ-026 Reset in RUN or DONE SHALL discard the operation with no result emitted.
REQ-027 After rst deasserts, the first accept SHALL be possible at the next rising edge.

Structure
REQ-028 Shared package cmp_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the result encoding constants (GT, EQ, LS).
REQ-029 Sub-module cmp2_slice SHALL be purely combinational.
- Inputs: two 2-bit values.
- Outputs: one-hot gt/eq/ls.
- Exactly one instance.

Verification (WIDTH=8)
REQ-030 a=8'hA5, x=8'hA5, res_ready=1 -> res_valid after edge 4, eq=1, gt=0, ls=0.
REQ-031 a=8'h80, x=8'h7F -> pair 0 differs, res_valid after edge 1, gt=1.
REQ-032 a=8'h12, x=8'h13 -> pair 3 differs, res_valid after edge 4, ls=1.
REQ-033 Backpressure and stability:
- Hold res_ready=0 for 5 cycles after res_valid, with start_valid=1 and new operands.
- Required: gt/eq/ls stable, start_ready=0, no second accept.
- On res_ready=1: IDLE, then second operation accepted.
REQ-034 Reset mid-RUN: assert rst between edges 1 and 2 of a=8'h01, x=8'h02 -> immediately res_valid=0, start_ready=1, busy=0; no result after release.
REQ-035 Operand change: change a and x every cycle after accepting a=8'h40, x=8'h3F -> result gt=1 after edge 1.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg
// Shared definitions for the serial comparator controller.
//   state_t   : controller FSM states (IDLE, RUN, DONE)
//   GT/EQ/LS  : one-hot result encodings, bit order {gt, eq, ls}
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LS = 3'b001;

endpackage

// File: rtl/cmp2_slice.sv
// cmp2_slice
// Purely combinational magnitude compare of two unsigned 2-bit values.
// Ports:
//   i_a, i_b : 2-bit operands
//   o_gt     : i_a > i_b
//   o_eq     : i_a == i_b
//   o_ls     : i_a < i_b
// Exactly one output is high for any input pair.
module cmp2_slice (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic       o_gt,
  output logic       o_eq,
  output logic       o_ls
);

  assign o_gt = (i_a > i_b);
  assign o_eq = (i_a == i_b);
  assign o_ls = (i_a < i_b);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl
// Compares two unsigned WIDTH-bit operands two bits per cycle, most
// significant pair first, exiting early on the first unequal pair.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   start_valid/ready    : operand handshake (a, x captured on accept)
//   a, x                 : operands A and B
//   res_valid/res_ready  : result handshake
//   gt, eq, ls           : one-hot result, held until res_ready
//   busy                 : high while an operation is in RUN or DONE
module serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] x,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             gt,
  output logic             eq,
  output logic             ls,
  output logic             busy
);

  localparam int NPAIRS = WIDTH / 2;
  localparam int IDX_W  = (NPAIRS <= 1) ? 1 : $clog2(NPAIRS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPAIRS - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_x;
  logic [IDX_W-1:0] r_idx;
  logic [2:0]       r_res;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_x_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [2:0]       w_res_nxt;

  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_x_sh;
  logic             w_gt;
  logic             w_eq;
  logic             w_ls;

  // Shifting left by 2*j brings pair j to the top two bits, so the slice
  // always looks at a fixed position instead of a variable part-select.
  assign w_a_sh = r_a << {r_idx, 1'b0};
  assign w_x_sh = r_x << {r_idx, 1'b0};

  cmp2_slice u_slice (
    .i_a  (w_a_sh[WIDTH-1 -: 2]),
    .i_b  (w_x_sh[WIDTH-1 -: 2]),
    .o_gt (w_gt),
    .o_eq (w_eq),
    .o_ls (w_ls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_x     <= '0;
      r_idx   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_x     <= w_x_nxt;
      r_idx   <= w_idx_nxt;
      r_res   <= w_res_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_x_nxt     = r_x;
    w_idx_nxt   = r_idx;
    w_res_nxt   = r_res;
    case (r_state)
      IDLE: begin
        if (start_valid) begin
          w_a_nxt     = a;
          w_x_nxt     = x;
          w_idx_nxt   = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (!w_eq) begin
          // Higher pairs were equal, so this pair alone decides the order.
          w_res_nxt   = w_gt ? GT : LS;
          w_state_nxt = DONE;
        end else if (r_idx == LAST_IDX) begin
          w_res_nxt   = EQ;
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          w_res_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_res_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign start_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign res_valid   = (r_state == DONE);
  // r_res is only non-zero in DONE, so the flags are zero everywhere else.
  assign gt          = r_res[2];
  assign eq          = r_res[1];
  assign ls          = r_res[0];

  // w_ls is implied by !w_gt && !w_eq; it is consumed only for completeness.
  logic w_unused;
  assign w_unused = w_ls;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
module tb_serial_cmp_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] x;
  logic         res_valid;
  logic         res_ready;
  logic         gt, eq, ls;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  serial_cmp_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .x           (x),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .gt          (gt),
    .eq          (eq),
    .ls          (ls),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: ordering is plain integer comparison of the operands.
  function automatic logic [2:0] ref_res(input logic [W-1:0] ra, input logic [W-1:0] rx);
    if (ra > rx)       return 3'b100;
    else if (ra == rx) return 3'b010;
    else               return 3'b001;
  endfunction

  // Reference latency: edges after accept until the result appears. The
  // first differing pair is the pair holding the highest differing bit.
  function automatic int ref_lat(input logic [W-1:0] ra, input logic [W-1:0] rx);
    logic [W-1:0] d;
    d = ra ^ rx;
    for (int p = W - 1; p >= 0; p--)
      if (d[p]) return (W - 1 - p) / 2 + 1;
    return W / 2;
  endfunction

  // One full operation. scramble: change a/x every cycle after accept.
  // hold: cycles of res_ready=0 after result, presenting (na, nx) meanwhile.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ox,
                       input bit scramble, input int hold,
                       input logic [W-1:0] na, input logic [W-1:0] nx);
    int k;
    logic [2:0] exp_r;
    exp_r = ref_res(oa, ox);
    k = 0;
    while (!start_ready && k < 20) begin tick(); k++; end
    chk("ready_before_accept", start_ready, 1'b1);
    res_ready   = 1'b0;
    start_valid = 1'b1;
    a = oa;
    x = ox;
    tick();
    start_valid = 1'b0;
    chk("busy_after_accept", {busy, start_ready}, 2'b10);
    k = 0;
    while (!res_valid && k < 20) begin
      if (scramble) begin
        a = W'($urandom);
        x = W'($urandom);
      end
      tick();
      k++;
    end
    chk("latency", k, ref_lat(oa, ox));
    chk("result", {gt, eq, ls}, exp_r);
    for (int h = 0; h < hold; h++) begin
      start_valid = 1'b1;
      a = na;
      x = nx;
      tick();
      chk("hold_valid", {res_valid, start_ready, busy}, 3'b101);
      chk("hold_result", {gt, eq, ls}, exp_r);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("release_state", {res_valid, start_ready, busy}, 3'b010);
    chk("release_flags", {gt, eq, ls}, 3'b000);
  endtask

  initial begin
    logic [W-1:0] ra, rx;
    rst = 1'b1;
    start_valid = 1'b0;
    res_ready = 1'b0;
    a = '0;
    x = '0;
    #2;
    chk("reset_outputs", {start_ready, busy, res_valid, gt, eq, ls}, 6'b100000);
    tick();
    tick();
    rst = 1'b0;

    // Directed cases.
    do_op(8'hA5, 8'hA5, 1'b0, 0, '0, '0);
    do_op(8'h80, 8'h7F, 1'b0, 0, '0, '0);
    do_op(8'h12, 8'h13, 1'b0, 0, '0, '0);
    do_op(8'h40, 8'h3F, 1'b1, 0, '0, '0);

    // Backpressure: new operands presented while result is held.
    do_op(8'h0C, 8'h0D, 1'b0, 5, 8'h9A, 8'h9A);
    start_valid = 1'b1;
    do_op(8'h9A, 8'h9A, 1'b0, 0, '0, '0);

    // Reset mid-RUN.
    start_valid = 1'b1;
    a = 8'h01;
    x = 8'h02;
    tick();
    start_valid = 1'b0;
    tick();
    chk("midrun_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_reset", {res_valid, start_ready, busy, gt, eq, ls}, 6'b010000);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_result_after_reset", {res_valid, busy}, 2'b00);
    end
    // First accept right after reset release.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    do_op(8'hF0, 8'h0F, 1'b0, 0, '0, '0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rx = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      if ($urandom_range(0, 3) == 0) rx = ra ^ W'(1 << $urandom_range(0, W - 1));
      do_op(ra, rx, 1'($urandom_range(0, 1)), $urandom_range(0, 2), W'($urandom), W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
